// File: rtl/keypad_debug_display.sv
// Keypad bring-up display: per-key synchroniser, press counter and hold stretcher
// driving one active-low 7-segment digit per keypad line.
module keypad_debug_display #(
  parameter int NUM_KEYS    = 4,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int TIMER_W     = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   keypresses,
  input  logic                  mode,
  input  logic                  clear,
  output logic [7*NUM_KEYS-1:0] segs,
  output logic [NUM_KEYS-1:0]   active
);

  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES);
  localparam logic [6:0]         BLANK     = 7'b111_1111;

  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'b100_0000;
      4'h1: f = 7'b111_1001;
      4'h2: f = 7'b010_0100;
      4'h3: f = 7'b011_0000;
      4'h4: f = 7'b001_1001;
      4'h5: f = 7'b001_0010;
      4'h6: f = 7'b000_0010;
      4'h7: f = 7'b111_1000;
      4'h8: f = 7'b000_0000;
      4'h9: f = 7'b001_0000;
      4'hA: f = 7'b000_1000;
      4'hB: f = 7'b000_0011;
      4'hC: f = 7'b100_0110;
      4'hD: f = 7'b010_0001;
      4'hE: f = 7'b000_0110;
      default: f = 7'b000_1110;
    endcase
    return f;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic               r_s1;
      logic               r_s2;
      logic               r_prev;
      logic               r_act_d;
      logic               r_active;
      logic [3:0]         r_cnt;
      logic [TIMER_W-1:0] r_tmr;
      logic [6:0]         r_seg;
      logic               w_k;
      logic               w_ev;
      logic               w_act;

      assign w_k   = r_s2;
      assign w_ev  = w_k & ~r_prev;
      assign w_act = w_k | (r_tmr != '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1     <= 1'b0;
          r_s2     <= 1'b0;
          r_prev   <= 1'b0;
          r_act_d  <= 1'b0;
          r_active <= 1'b0;
          r_cnt    <= '0;
          r_tmr    <= '0;
          r_seg    <= BLANK;
        end else begin
          r_s1    <= keypresses[gi];
          r_s2    <= r_s1;
          r_prev  <= w_k;
          r_act_d <= w_act;
          // clear leaves the synchroniser alone so a held key is not recounted
          if (clear) begin
            r_cnt <= '0;
            r_tmr <= '0;
          end else begin
            if (w_ev)
              r_cnt <= r_cnt + 4'd1;
            if (w_k)
              r_tmr <= HOLD_LOAD;
            else if (r_tmr != '0)
              r_tmr <= r_tmr - TIMER_W'(1);
          end
          // output stage sits one edge behind the counter/timer stage
          r_active <= r_act_d;
          if (mode)
            r_seg <= font(r_cnt);
          else
            r_seg <= r_act_d ? font(4'(gi + 1)) : BLANK;
        end
      end

      assign segs[7*gi +: 7] = r_seg;
      assign active[gi]      = r_active;
    end
  endgenerate

endmodule

// File: tb/tb_keypad_debug_display.sv
// Directed bench for keypad_debug_display with a short hold time.
module tb_keypad_debug_display;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] keypresses;
  logic          mode;
  logic          clear;
  logic [7*NK-1:0] segs;
  logic [NK-1:0] active;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] BLANK = 7'b111_1111;
  localparam logic [6:0] FONT [16] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
    7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
  };

  keypad_debug_display #(
    .NUM_KEYS   (NK),
    .HOLD_CYCLES(5),
    .TIMER_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keypresses(keypresses),
    .mode      (mode),
    .clear     (clear),
    .segs      (segs),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic tap(input logic [NK-1:0] k);
    keypresses = k;
    step(2);
    keypresses = '0;
    step(2);
  endtask

  initial begin
    rst        = 1'b1;
    keypresses = 4'b1111;
    mode       = 1'b0;
    clear      = 1'b0;

    // reset with all keys high
    step(1);
    chk("rst_segs_a", 64'(segs), 64'({4{BLANK}}));
    chk("rst_act_a", 64'(active), 64'h0);
    step(1);
    chk("rst_segs_b", 64'(segs), 64'({4{BLANK}}));
    chk("rst_act_b", 64'(active), 64'h0);
    rst = 1'b0;
    step(3);
    chk("post_rst_e2_segs", 64'(segs), 64'({4{BLANK}}));
    step(1);
    chk("post_rst_e3_segs", 64'(segs), 64'({FONT[4], FONT[3], FONT[2], FONT[1]}));
    chk("post_rst_e3_act", 64'(active), 64'hF);

    // hold stretch: one-cycle tap on key0
    keypresses = '0;
    do_reset();
    step(5);
    keypresses = 4'b0001;
    step(1);
    keypresses = '0;
    step(2);
    chk("tap_e2_act", 64'(active[0]), 64'h0);
    step(1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tap_hold%0d_act", i), 64'(active[0]), 64'h1);
      chk($sformatf("tap_hold%0d_seg", i), 64'(segs[6:0]), 64'(FONT[1]));
      step(1);
    end
    chk("tap_end_act", 64'(active[0]), 64'h0);
    chk("tap_end_seg", 64'(segs[6:0]), 64'(BLANK));

    // counting on key2 with wrap
    mode = 1'b1;
    do_reset();
    step(3);
    chk("cnt_init_segs", 64'(segs), 64'({4{FONT[0]}}));
    for (int n = 1; n <= 17; n++) begin
      tap(4'b0100);
      chk($sformatf("cnt_press%0d", n), 64'(segs[20:14]), 64'(FONT[n % 16]));
    end
    keypresses = 4'b0100;
    step(100);
    keypresses = '0;
    step(4);
    chk("cnt_long_hold", 64'(segs[20:14]), 64'(FONT[2]));

    // clear colliding with a press event on key1
    do_reset();
    step(3);
    for (int n = 0; n < 3; n++) tap(4'b0010);
    chk("clr_pre_cnt", 64'(segs[13:7]), 64'(FONT[3]));
    keypresses = 4'b0010;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
    chk("clr_collide_seg", 64'(segs[13:7]), 64'(FONT[0]));
    step(10);
    chk("clr_held_seg", 64'(segs[13:7]), 64'(FONT[0]));
    chk("clr_held_act", 64'(active[1]), 64'h1);
    keypresses = '0;
    step(4);

    // multi-key with mode switching
    mode = 1'b0;
    keypresses = 4'b1001;
    do_reset();
    step(4);
    chk("multi_id_segs", 64'(segs), 64'({FONT[4], BLANK, BLANK, FONT[1]}));
    mode = 1'b1;
    step(1);
    chk("multi_cnt_segs", 64'(segs), 64'({FONT[1], FONT[0], FONT[0], FONT[1]}));
    mode = 1'b0;
    step(1);
    chk("multi_id2_segs", 64'(segs), 64'({FONT[4], BLANK, BLANK, FONT[1]}));

    // reset in the middle of key3's hold period
    keypresses = 4'b0001;
    step(3);
    chk("midhold_act", 64'(active), 64'h9);
    rst = 1'b1;
    step(1);
    chk("midhold_rst_act", 64'(active), 64'h0);
    chk("midhold_rst_segs", 64'(segs), 64'({4{BLANK}}));
    rst = 1'b0;
    step(3);
    chk("relight_e2_segs", 64'(segs), 64'({4{BLANK}}));
    step(1);
    chk("relight_e3_segs", 64'(segs), 64'({BLANK, BLANK, BLANK, FONT[1]}));
    chk("relight_e3_act", 64'(active), 64'h1);
    mode = 1'b1;
    step(1);
    chk("relight_cnt_segs", 64'(segs), 64'({FONT[0], FONT[0], FONT[0], FONT[1]}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
